// File: rtl/mac_pkg.sv
// mac_pkg: shared drain FSM states and default geometry for the SRAM C result drain
package mac_pkg;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} drain_state_t;
  localparam int DEF_M = 4;
  localparam int DEF_N = 4;
  localparam int DEF_K = 4;
  localparam int DEF_DW = 32;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int ROW_W = $clog2(DEF_M);
  localparam int COL_W = $clog2(DEF_N);
  localparam int RES_W = DEF_DW * 2 + $clog2(DEF_K);
endpackage

// File: rtl/mac_drain_fifo.sv
// mac_drain_fifo: small synchronous FIFO; read data reads as zero while empty
module mac_drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign pop_ok = pop & !empty;
  assign push_ok = push & (!full | pop_ok);
  assign rdata = empty ? '0 : mem[rd_ptr];
  // pointer and occupancy bookkeeping; push+pop on a full FIFO keeps the count
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;
  // a push into a full FIFO is only legal when a pop frees a slot the same cycle
  always_ff @(posedge clk)
    if (resetn && push && full) assert (pop);
endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: reads the M x N result matrix from SRAM C row-major and streams it out; MAC_DRAIN_COORD_EN adds out_row/out_col
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N,
  parameter int K = DEF_K,
  parameter int DATA_WIDTH_INIT_MATRIX = DEF_DW,
  parameter int DATA_WIDTH_RESULT_MATRIX = DATA_WIDTH_INIT_MATRIX * 2 + $clog2(K),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  output logic                                busy,
  output logic                                drain_done,
  output logic                                matrix_c_re,
  output logic [$clog2(M)-1:0]                row_addr_c,
  output logic [$clog2(N)-1:0]                col_addr_c,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last
`ifdef MAC_DRAIN_COORD_EN
  ,
  output logic [$clog2(M)-1:0]                out_row,
  output logic [$clog2(N)-1:0]                out_col
`endif
);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int DW = DATA_WIDTH_RESULT_MATRIX;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef MAC_DRAIN_COORD_EN
  localparam int FW = DW + 1 + RW + CW;
`else
  localparam int FW = DW + 1;
`endif
  drain_state_t state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic inflight, last_q, pop, re, last_issue, full, empty;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0] credit;
  logic [FW-1:0] push_word, pop_word;
  assign out_valid = !empty;
  assign pop = out_valid & out_ready;
  assign credit = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign re = state == READ && credit < (CNT_W + 1)'(FIFO_DEPTH);
  assign last_issue = re && row == RW'(M - 1) && col == CW'(N - 1);
  assign matrix_c_re = re;
  assign row_addr_c = re ? row : '0;
  assign col_addr_c = re ? col : '0;
  assign busy = state != IDLE;
  assign drain_done = state == DONE;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  // next state; FLUSH ends once the FIFO drains this cycle with nothing left in flight
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (start ? READ : IDLE) :
                state == READ  ? (last_issue ? FLUSH : READ) :
                state == FLUSH ? ((occ == CNT_W'(pop) && !inflight) ? DONE : FLUSH) :
                IDLE;
  end
  // row-major read address counters, advancing on each issued read
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      row <= '0;
      col <= '0;
    end else if (re) begin
      col <= col == CW'(N - 1) ? '0 : col + 1'b1;
      row <= col != CW'(N - 1) ? row : row == RW'(M - 1) ? '0 : row + 1'b1;
    end
  // one-cycle read-in-flight marker and last tag, aligned with SRAM read data
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      inflight <= 1'b0;
      last_q <= 1'b0;
    end else begin
      inflight <= re;
      last_q <= last_issue;
    end
`ifdef MAC_DRAIN_COORD_EN
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  // coordinates of the read in flight, stored alongside its data
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_addr_c;
      col_q <= col_addr_c;
    end
  assign push_word = {row_q, col_q, last_q, data_in_c};
  assign {out_row, out_col, out_last, out_data} = pop_word;
`else
  assign push_word = {last_q, data_in_c};
  assign {out_last, out_data} = pop_word;
`endif
  mac_drain_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(inflight),
    .pop(pop),
    .wdata(push_word),
    .rdata(pop_word),
    .full(full),
    .empty(empty),
    .count(occ)
  );
endmodule

// File: tb/tb_mac_result_drain.sv
// tb_mac_result_drain: directed and randomized drains of a 4x4 SRAM C checked against a row-major reference
module tb_mac_result_drain;
  localparam int M = 4;
  localparam int N = 4;
  localparam int DW = 66;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, drain_done, matrix_c_re, out_valid, out_last;
  logic [1:0] row_addr_c, col_addr_c;
  logic [DW-1:0] data_in_c = '0;
  logic [DW-1:0] out_data;
`ifdef MAC_DRAIN_COORD_EN
  logic [1:0] out_row, out_col;
`endif

  mac_result_drain dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .drain_done(drain_done),
    .matrix_c_re(matrix_c_re), .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .data_in_c(data_in_c), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef MAC_DRAIN_COORD_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram [M*N];
  always @(posedge clk) if (matrix_c_re) data_in_c <= sram[int'(row_addr_c) * N + int'(col_addr_c)];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] cap_data[$];
  logic cap_last[$];
  int cap_cyc[$];
  int cap_rc[$];
  int re_count, done_count, done_cyc, first_re, first_valid;
  logic held, held_last, prev_done;
  logic [DW-1:0] held_data;

  task automatic clear();
    cap_data.delete(); cap_last.delete(); cap_cyc.delete(); cap_rc.delete();
    re_count = 0; done_count = 0; done_cyc = -1; first_re = -1; first_valid = -1;
    held = 1'b0; prev_done = 1'b0;
  endtask

  always @(negedge clk) if (resetn) begin
    if (matrix_c_re) begin
      check("read_addr", 128'(int'(row_addr_c) * N + int'(col_addr_c)), 128'(re_count));
      if (first_re < 0) first_re = cyc;
      re_count++;
    end else check("addr_zero_when_idle", {row_addr_c, col_addr_c}, 0);
    if (held) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, held_data);
      check("stall_last", out_last, held_last);
    end
    held = out_valid && !out_ready;
    held_data = out_data;
    held_last = out_last;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_last.push_back(out_last);
      cap_cyc.push_back(cyc);
`ifdef MAC_DRAIN_COORD_EN
      cap_rc.push_back(int'(out_row) * N + int'(out_col));
`endif
    end
    check("outstanding", (re_count - cap_data.size()) <= DEPTH, 1);
    if (prev_done) check("busy_after_done", busy, 0);
    prev_done = drain_done;
    if (drain_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, drain_done, matrix_c_re, out_valid, out_last}, 0);
    check({tag, "_addr"}, {row_addr_c, col_addr_c}, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  task automatic drain(input int mode, input int restart_at, input int abort_at, output int start_edge);
    bit restarted;
    int rel;
    restarted = 0;
    clear();
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start_edge = cyc;
    start = 1'b0;
    check("busy_on_start", busy, 1);
    for (int i = 0; i < 400; i++) begin
      rel = first_valid < 0 ? -1 : cyc - first_valid;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? !(rel >= 3 && rel <= 10) : 1'($urandom_range(0, 1));
      if (restart_at >= 0 && !restarted && cap_data.size() >= restart_at) begin
        start = 1'b1;
        restarted = 1;
      end else start = 1'b0;
      if (abort_at >= 0 && cap_data.size() >= abort_at) begin
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("held_reset");
        resetn = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("no_done_after_abort", done_count, 0);
        return;
      end
      @(posedge clk); #1;
      if (done_count > 0 && cyc > done_cyc + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int mode, input int start_edge);
    check({tag, "_beats"}, cap_data.size(), M * N);
    check({tag, "_reads"}, re_count, M * N);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_first_re"}, first_re, start_edge);
    check({tag, "_first_valid"}, first_valid, start_edge + 2);
    for (int i = 0; i < cap_data.size() && i < M * N; i++) begin
      check({tag, "_data"}, cap_data[i], sram[i]);
      check({tag, "_last"}, cap_last[i], i == M * N - 1);
`ifdef MAC_DRAIN_COORD_EN
      check({tag, "_coord"}, cap_rc[i], i);
`endif
      if (mode == 0) check({tag, "_back_to_back"}, cap_cyc[i], cap_cyc[0] + i);
    end
    if (cap_cyc.size() == M * N) check({tag, "_done_timing"}, done_cyc, cap_cyc[M*N-1] + 1);
  endtask

  initial begin
    int se;
    for (int i = 0; i < M * N; i++) sram[i] = DW'(16 * (i / N) + (i % N));
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_clocked");
    resetn = 1'b1;
    drain(0, -1, -1, se);
    verify("full_rate", 0, se);
    drain(1, -1, -1, se);
    verify("stall", 1, se);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < M * N; i++) sram[i] = DW'({$urandom, $urandom, $urandom});
      drain(2, -1, -1, se);
      verify("random_ready", 2, se);
    end
    drain(0, 3, -1, se);
    verify("restart_ignored", 0, se);
    drain(0, -1, 7, se);
    drain(0, -1, -1, se);
    verify("after_abort", 0, se);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
